// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction-memory req/ack fetch, IF/ID register with stall hold and redirect flush.
// Optional build macro FETCH_PERF_EN adds perf_fetch / perf_redirect event counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic        jal,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_redirect
`endif
);

  // state | meaning
  // IDLE  | no request outstanding; next cycle issues a fetch at pc
  // FETCH | imem_req high, imem_addr=pc held until imem_ack
  // HOLD  | fetched word parked in hold_buf until stall drops
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_tgt_q, kill_tgt_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        redirect;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = valid_q & ~stall & (jr | jump | jal | (branch & zero));

  always_comb begin
    if (jr)               redirect_tgt = jr_target & 32'hFFFF_FFFC;
    else if (jump | jal)  redirect_tgt = {pc4_q[31:28], jump_idx, 2'b00};
    else                  redirect_tgt = pc4_q + (branch_off << 2);
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    kill_tgt_d   = kill_tgt_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    // Unstalled IF/ID is consumed by decode (or flushed by a redirect): bubble unless refilled below
    if (!stall) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (redirect) pc_d = redirect_tgt;
        else          state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_IDLE;
          if (kill_q) begin
            pc_d   = kill_tgt_q;
            kill_d = 1'b0;
          end else if (redirect) begin
            pc_d = redirect_tgt;
          end else begin
            pc_d = pc_plus4;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = pc_plus4;
              state_d      = S_HOLD;
            end else begin
              instr_d = imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end
        end else if (redirect) begin
          kill_d     = 1'b1;
          kill_tgt_d = redirect_tgt;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = S_IDLE;
        end else if (!stall) begin
          instr_d = hold_instr_q;
          pc4_d   = hold_pc4_q;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      kill_q       <= 1'b0;
      kill_tgt_q   <= 32'd0;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d & 32'hFFFF_FFFC;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      kill_q       <= kill_d;
      kill_tgt_q   <= kill_tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_redirect_q;

  // A valid_d with stall low is always a fresh write; under stall it is only the held copy
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q    <= 32'd0;
      perf_redirect_q <= 32'd0;
    end else begin
      if (valid_d && !stall) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (redirect)          perf_redirect_q <= perf_redirect_q + 32'd1;
    end
  end

  assign perf_fetch    = perf_fetch_q;
  assign perf_redirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table for redirect targets, directed kill/stall/reset sequences,
// and a randomized run against a queue-based program-order reference model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, stall, branch, zero, jump, jal, jr, ifid_valid;
  logic [31:0] imem_addr, imem_rdata, branch_off, jr_target, ifid_instr, ifid_pc4;
  logic [25:0] jump_idx;

  int n_pass = 0;
  int n_total = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .branch(branch), .zero(zero), .branch_off(branch_off),
    .jump(jump), .jal(jal), .jump_idx(jump_idx), .jr(jr), .jr_target(jr_target),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d so far)", n_pass, n_total);
    $fatal(1);
  end

  typedef struct {
    logic [31:0] pc4;
    logic        br, z, jmp, jl, jrr;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] jtgt;
    logic [31:0] exp_next;
    logic        exp_redir;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic [31:0] pc4, logic br, logic z, logic jmp, logic jl, logic jrr,
                              logic [31:0] off, logic [25:0] idx, logic [31:0] jtgt,
                              logic [31:0] exp_next, logic exp_redir);
    vec_t v;
    v.pc4 = pc4; v.br = br; v.z = z; v.jmp = jmp; v.jl = jl; v.jrr = jrr;
    v.off = off; v.idx = idx; v.jtgt = jtgt; v.exp_next = exp_next; v.exp_redir = exp_redir;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic check1(string name, logic act, logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_ctl();
    branch = 0; zero = 0; jump = 0; jal = 0; jr = 0;
    branch_off = 0; jump_idx = 0; jr_target = 0;
  endtask

  task automatic do_reset();
    clear_ctl();
    stall = 0; imem_ack = 0; imem_rdata = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic wait_req(string name);
    logic ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin
        ok = 1;
        break;
      end
      tick();
    end
    check1({name, "_req_seen"}, ok, 1'b1);
  endtask

  task automatic ack_word(logic [31:0] data);
    imem_ack = 1; imem_rdata = data;
    tick();
    imem_ack = 0; imem_rdata = 32'hXXXX_XXXX;
  endtask

  // Bring IF/ID to a valid instruction whose PC+4 is p, with no request outstanding
  task automatic goto_pc4(logic [31:0] p, string name);
    do_reset();
    wait_req(name);
    ack_word(mem_word(32'h0));
    jr = 1; jr_target = p - 32'd4;
    tick();
    clear_ctl();
    wait_req(name);
    ack_word(mem_word(p - 32'd4));
    check32({name, "_setup_pc4"}, ifid_pc4, p);
  endtask

  // random-phase reference model state
  logic [31:0] exp_addr, cur_addr, m_instr, m_pc4, tgt;
  logic        m_valid, in_req, doomed, redir, acc;
  int          ack_delay, idle_cnt;
  logic [31:0] pend_instr[$];
  logic [31:0] pend_pc4[$];

  initial begin
    clear_ctl();
    stall = 0; imem_ack = 0; imem_rdata = 0; rst = 1;

    // reset values and first fetch
    do_reset();
    check1("reset_req", imem_req, 1'b0);
    check1("reset_valid", ifid_valid, 1'b0);
    check32("reset_instr", ifid_instr, NOP);
    check32("reset_pc4", ifid_pc4, 32'h0);
    wait_req("first");
    check32("first_addr", imem_addr, 32'h0);
    tick();
    check32("first_addr_held", imem_addr, 32'h0);
    ack_word(32'h8C01_0004);
    check32("first_instr", ifid_instr, 32'h8C01_0004);
    check32("first_pc4", ifid_pc4, 32'h4);
    check1("first_valid", ifid_valid, 1'b1);
    wait_req("second");
    check32("second_addr", imem_addr, 32'h4);

    // redirect target table
    vecs[0] = mk(32'h0000_0100, 1, 1, 0, 0, 0, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'h0000_00F8, 1);
    vecs[1] = mk(32'h0000_0100, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'h0000_0100, 0);
    vecs[2] = mk(32'h4000_0010, 0, 0, 0, 1, 0, 32'h0, 26'h000_0040, 32'h0, 32'h4000_0100, 1);
    vecs[3] = mk(32'h8000_0008, 0, 0, 1, 0, 0, 32'h0, 26'h3FF_FFFF, 32'h0, 32'h8FFF_FFFC, 1);
    vecs[4] = mk(32'h0000_0020, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0000_1237, 32'h0000_1234, 1);
    vecs[5] = mk(32'h0000_0040, 1, 1, 1, 0, 1, 32'h4, 26'h5, 32'h0000_0300, 32'h0000_0300, 1);
    vecs[6] = mk(32'h0000_0040, 1, 1, 1, 0, 0, 32'h4, 26'h80, 32'h0, 32'h0000_0200, 1);
    vecs[7] = mk(32'hFFFF_FFF0, 1, 1, 0, 0, 0, 32'h10, 26'h0, 32'h0, 32'h0000_0030, 1);
    vecs[8] = mk(32'h0000_1000, 1, 1, 0, 0, 0, 32'h3, 26'h0, 32'h0, 32'h0000_100C, 1);

    for (int i = 0; i < 9; i++) begin
      goto_pc4(vecs[i].pc4, $sformatf("vec%0d", i));
      branch = vecs[i].br; zero = vecs[i].z; jump = vecs[i].jmp; jal = vecs[i].jl; jr = vecs[i].jrr;
      branch_off = vecs[i].off; jump_idx = vecs[i].idx; jr_target = vecs[i].jtgt;
      tick();
      clear_ctl();
      check1($sformatf("vec%0d_valid", i), ifid_valid, 1'b0);
      if (vecs[i].exp_redir) begin
        check32($sformatf("vec%0d_flush_instr", i), ifid_instr, NOP);
        check1($sformatf("vec%0d_req_gap", i), imem_req, 1'b0);
        tick();
      end
      check1($sformatf("vec%0d_req", i), imem_req, 1'b1);
      check32($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_next);
    end

    // redirect while a fetch awaits ack: address held, data discarded, then target
    goto_pc4(32'h20, "kill");
    stall = 1;
    tick();
    check1("kill_req", imem_req, 1'b1);
    check32("kill_addr0", imem_addr, 32'h20);
    check1("kill_ifid_held", ifid_valid, 1'b1);
    stall = 0; jr = 1; jr_target = 32'h200;
    tick();
    clear_ctl();
    check1("kill_flush", ifid_valid, 1'b0);
    check32("kill_addr1", imem_addr, 32'h20);
    tick();
    check32("kill_addr2", imem_addr, 32'h20);
    ack_word(32'hDEAD_BEEF);
    check1("kill_discard", ifid_valid, 1'b0);
    check1("kill_idle", imem_req, 1'b0);
    tick();
    check1("kill_req_new", imem_req, 1'b1);
    check32("kill_addr_new", imem_addr, 32'h200);

    // stall across the ack: HOLD without request, word released the cycle after stall drops
    do_reset();
    wait_req("hold");
    stall = 1;
    ack_word(32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      check1($sformatf("hold%0d_noreq", i), imem_req, 1'b0);
      check1($sformatf("hold%0d_valid", i), ifid_valid, 1'b0);
      if (i < 3) tick();
    end
    stall = 0;
    tick();
    check32("hold_instr", ifid_instr, 32'h1234_5678);
    check32("hold_pc4", ifid_pc4, 32'h4);
    check1("hold_valid", ifid_valid, 1'b1);
    wait_req("hold_next");
    check32("hold_next_addr", imem_addr, 32'h4);

    // reset mid-FETCH; late ack ignored
    rst = 1;
    tick();
    check1("rstmid_req", imem_req, 1'b0);
    check1("rstmid_valid", ifid_valid, 1'b0);
    check32("rstmid_instr", ifid_instr, NOP);
    check32("rstmid_pc4", ifid_pc4, 32'h0);
    rst = 0;
    ack_word(32'h0BAD_0BAD);
    check1("rstmid_late_ack", ifid_valid, 1'b0);
    check1("rstmid_req_again", imem_req, 1'b1);
    check32("rstmid_addr", imem_addr, 32'h0);

    // randomized run against a program-order model
    do_reset();
    exp_addr = 32'h0; m_valid = 0; m_instr = NOP; m_pc4 = 0;
    in_req = 0; doomed = 0; idle_cnt = 0; ack_delay = 0; cur_addr = 0;
    pend_instr.delete(); pend_pc4.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check1("rnd_valid", ifid_valid, m_valid);
      if (m_valid) begin
        check32("rnd_instr", ifid_instr, m_instr);
        check32("rnd_pc4", ifid_pc4, m_pc4);
      end
      if (pend_instr.size() != 0) begin
        check1("rnd_hold_noreq", imem_req, 1'b0);
        idle_cnt = 0;
      end else if (imem_req) begin
        idle_cnt = 0;
        if (!in_req) begin
          check32("rnd_addr", imem_addr, exp_addr);
          in_req = 1;
          cur_addr = imem_addr;
          ack_delay = $urandom_range(0, 3);
        end else begin
          check32("rnd_addr_stable", imem_addr, cur_addr);
        end
      end else begin
        idle_cnt++;
        if (idle_cnt > 3) begin
          check1("rnd_req_timeout", 1'b0, 1'b1);
          idle_cnt = 0;
        end
      end

      stall = ($urandom_range(0, 99) < 25);
      imem_ack = 0;
      imem_rdata = $urandom;
      if (in_req && imem_req) begin
        if (ack_delay == 0) begin
          imem_ack = 1;
          imem_rdata = mem_word(cur_addr);
        end else begin
          ack_delay--;
        end
      end else if (!imem_req && $urandom_range(0, 99) < 5) begin
        imem_ack = 1;
      end
      branch = ($urandom_range(0, 99) < 8);
      zero = $urandom_range(0, 1) == 1;
      jump = ($urandom_range(0, 99) < 5);
      jal = ($urandom_range(0, 99) < 5);
      jr = ($urandom_range(0, 99) < 5);
      jr_target = $urandom;
      jump_idx = 26'($urandom);
      begin
        logic [31:0] r;
        r = $urandom;
        branch_off = {{22{r[9]}}, r[9:0]};
      end

      redir = m_valid && !stall && (jr || jump || jal || (branch && zero));
      if (jr) tgt = {jr_target[31:2], 2'b00};
      else if (jump || jal) tgt = {m_pc4[31:28], jump_idx, 2'b00};
      else tgt = m_pc4 + branch_off * 32'd4;
      acc = imem_ack && imem_req;
      if (acc) begin
        if (!doomed && !redir) begin
          pend_instr.push_back(mem_word(cur_addr));
          pend_pc4.push_back(cur_addr + 32'd4);
          exp_addr = cur_addr + 32'd4;
        end
        doomed = 0;
        in_req = 0;
      end else if (redir && in_req) begin
        doomed = 1;
      end
      if (redir) begin
        pend_instr.delete();
        pend_pc4.delete();
        exp_addr = tgt;
        m_valid = 0;
      end else if (!stall) begin
        if (pend_instr.size() != 0) begin
          m_instr = pend_instr.pop_front();
          m_pc4 = pend_pc4.pop_front();
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      tick();
    end
    clear_ctl();
    stall = 0; imem_ack = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
